// File: rtl/instr_decode_stage.sv
// rtl/instr_decode_stage.sv - decode stage: splits a fetched word into operand/control fields in a single-entry slot
module instr_decode_stage #(
  parameter int PC_W  = 32,
  parameter int IMM_W = 18
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      out_op,
  output logic            out_imm_sel,
  output logic [3:0]      out_rd,
  output logic [3:0]      out_rs1,
  output logic [3:0]      out_rs2,
  output logic [31:0]     out_imm,
  output logic [PC_W-1:0] out_target,
  output logic [PC_W-1:0] out_pc,
  output logic            out_wr_en,
  output logic            out_is_branch,
  output logic [1:0]      out_is_mem,
  output logic            out_illegal
);

  localparam logic [4:0] OP_CMP  = 5'b00101;
  localparam logic [4:0] OP_ASR  = 5'b01100;
  localparam logic [4:0] OP_LD   = 5'b01110;
  localparam logic [4:0] OP_ST   = 5'b01111;
  localparam logic [4:0] OP_BEQ  = 5'b10000;
  localparam logic [4:0] OP_CALL = 5'b10011;
  localparam logic [4:0] OP_RET  = 5'b10100;
  localparam logic [3:0] LINK_REG = 4'hF;

  logic            valid_q;
  logic [4:0]      op_q;
  logic            imm_sel_q;
  logic [3:0]      rd_q, rs1_q, rs2_q;
  logic [31:0]     imm_q;
  logic [PC_W-1:0] target_q, pc_q;
  logic            wr_en_q, is_branch_q, illegal_q;
  logic [1:0]      is_mem_q;

  logic [4:0]      op_d;
  logic [3:0]      rd_d, rs1_d, rs2_d;
  logic [31:0]     imm_d;
  logic [PC_W-1:0] target_d;
  logic            wr_en_d, is_branch_d, illegal_d;
  logic [1:0]      is_mem_d;
  logic            load;

  assign in_ready = !valid_q || out_ready;
  assign load     = in_valid && in_ready && !flush;

  assign op_d     = in_instr[31:27];
  assign imm_d    = {{(32-IMM_W){in_instr[IMM_W-1]}}, in_instr[IMM_W-1:0]};
  assign target_d = PC_W'(in_instr[26:0]);

  // Illegal opcodes keep their raw fields but behave as nop downstream.
  always_comb begin
    rd_d        = in_instr[25:22];
    rs1_d       = in_instr[21:18];
    rs2_d       = in_instr[17:14];
    wr_en_d     = 1'b0;
    is_branch_d = 1'b0;
    is_mem_d    = 2'b00;
    illegal_d   = 1'b0;
    if (op_d > OP_RET) begin
      illegal_d = 1'b1;
    end else begin
      wr_en_d     = ((op_d <= OP_ASR) && (op_d != OP_CMP)) || (op_d == OP_LD) || (op_d == OP_CALL);
      is_branch_d = (op_d >= OP_BEQ);
      if (op_d == OP_LD) is_mem_d = 2'b01;
      if (op_d == OP_ST) begin
        is_mem_d = 2'b10;
        rs2_d    = in_instr[25:22];
      end
      if (op_d == OP_CALL) rd_d = LINK_REG;
      if (op_d == OP_RET) rs1_d = LINK_REG;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q     <= 1'b0;
      op_q        <= '0;
      imm_sel_q   <= 1'b0;
      rd_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      imm_q       <= '0;
      target_q    <= '0;
      pc_q        <= '0;
      wr_en_q     <= 1'b0;
      is_branch_q <= 1'b0;
      is_mem_q    <= 2'b00;
      illegal_q   <= 1'b0;
    end else begin
      if (flush) begin
        valid_q <= 1'b0;
      end else if (load) begin
        valid_q <= 1'b1;
      end else if (out_ready) begin
        valid_q <= 1'b0;
      end
      if (load) begin
        op_q        <= op_d;
        imm_sel_q   <= in_instr[26];
        rd_q        <= rd_d;
        rs1_q       <= rs1_d;
        rs2_q       <= rs2_d;
        imm_q       <= imm_d;
        target_q    <= target_d;
        pc_q        <= in_pc;
        wr_en_q     <= wr_en_d;
        is_branch_q <= is_branch_d;
        is_mem_q    <= is_mem_d;
        illegal_q   <= illegal_d;
      end
    end
  end

  assign out_valid     = valid_q;
  assign out_op        = op_q;
  assign out_imm_sel   = imm_sel_q;
  assign out_rd        = rd_q;
  assign out_rs1       = rs1_q;
  assign out_rs2       = rs2_q;
  assign out_imm       = imm_q;
  assign out_target    = target_q;
  assign out_pc        = pc_q;
  assign out_wr_en     = wr_en_q;
  assign out_is_branch = is_branch_q;
  assign out_is_mem    = is_mem_q;
  assign out_illegal   = illegal_q;

endmodule
